// File: rtl/albacore_controller_ws.sv
`default_nettype none
// ============================================================================
// Module  : albacore_controller_ws
// Brief   : Multicycle albacore control FSM with memory handshake, timeout
//           fault, halt/resume, illegal-opcode trap and retired counter.
// Rev     : 1.0
// ============================================================================
module albacore_controller_ws #(
  parameter int OPCODE_W    = 4,
  parameter int ALU_OP_W    = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int RETIRE_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                neg,
  input  logic                mem_ready,
  input  logic                run,
  output logic                mem_req,
  output logic                s_addr,
  output logic                we_mem,
  output logic                en_inst,
  output logic                en_a,
  output logic                en_b,
  output logic                en_f,
  output logic                en_mdr,
  output logic                en_pc,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                s_regfile_din,
  output logic                s_regfile_rw,
  output logic                we_regfile,
  output logic                halted,
  output logic                fault,
  output logic [RETIRE_W-1:0] retired_count
);

  localparam int c_wait_w = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [c_wait_w-1:0] c_wait_last =
    (MEM_TIMEOUT > 0) ? c_wait_w'(MEM_TIMEOUT - 1) : '0;

  typedef enum logic [4:0] {
    S_HALT    = 5'd0,
    S_IFETCH  = 5'd1,
    S_DECODE  = 5'd2,
    S_EX_ALU  = 5'd3,
    S_EX_LD   = 5'd4,
    S_EX_ST   = 5'd5,
    S_EX_BR   = 5'd6,
    S_EX_BZ   = 5'd7,
    S_EX_BN   = 5'd8,
    S_EX_JAL  = 5'd9,
    S_EX_JR   = 5'd10,
    S_EX_QUIT = 5'd11,
    S_MEM_LD  = 5'd12,
    S_MEM_ST  = 5'd13,
    S_WB_ALU  = 5'd14,
    S_WB_LD   = 5'd15,
    S_WB_JAL  = 5'd16,
    S_FAULT   = 5'd17
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [c_wait_w-1:0]   r_wait;
  logic [RETIRE_W-1:0]   r_retired;
  logic                  w_illegal;
  logic                  w_timeout;
  logic [3:0]            w_alu;
  logic                  w_mem_req, w_s_addr, w_we_mem, w_en_inst, w_en_a, w_en_b;
  logic                  w_en_f, w_en_mdr, w_en_pc, w_din, w_rw, w_we_rf;

  // Opcodes wider than the base map trap whenever any upper bit is set.
  generate
    if (OPCODE_W > 4) begin : g_wide_op
      assign w_illegal = |opcode[OPCODE_W-1:4];
    end else begin : g_base_op
      assign w_illegal = 1'b0;
    end
  endgenerate

  // Fires on the MEM_TIMEOUT-th consecutive not-ready cycle; a ready wins.
  assign w_timeout = (MEM_TIMEOUT != 0) && (r_wait == c_wait_last) && !mem_ready;

  always_comb begin
    w_next    = r_state;
    w_mem_req = 1'b0;
    w_s_addr  = 1'b0;
    w_we_mem  = 1'b0;
    w_en_inst = 1'b0;
    w_en_a    = 1'b0;
    w_en_b    = 1'b0;
    w_en_f    = 1'b0;
    w_en_mdr  = 1'b0;
    w_en_pc   = 1'b0;
    w_alu     = 4'd0;
    w_din     = 1'b0;
    w_rw      = 1'b0;
    w_we_rf   = 1'b0;
    case (r_state)
      S_HALT: if (run) w_next = S_IFETCH;
      S_IFETCH: begin
        w_mem_req = 1'b1;
        if (mem_ready) begin
          w_en_inst = 1'b1;
          w_next    = S_DECODE;
        end else if (w_timeout) begin
          w_next = S_FAULT;
        end
      end
      S_DECODE: begin
        w_en_a = 1'b1;
        w_en_b = 1'b1;
        if (w_illegal) begin
          w_next = S_FAULT;
        end else begin
          case (opcode[3:0])
            4'd8:    w_next = S_EX_LD;
            4'd9:    w_next = S_EX_ST;
            4'd10:   w_next = S_EX_BR;
            4'd11:   w_next = S_EX_BZ;
            4'd12:   w_next = S_EX_BN;
            4'd13:   w_next = S_EX_JAL;
            4'd14:   w_next = S_EX_JR;
            4'd15:   w_next = S_EX_QUIT;
            default: w_next = S_EX_ALU;
          endcase
        end
      end
      S_EX_ALU: begin
        w_alu  = {1'b0, opcode[2:0]};
        w_en_f = 1'b1;
        w_next = S_WB_ALU;
      end
      S_EX_LD:  begin w_alu = 4'd8;  w_en_f = 1'b1; w_next = S_MEM_LD; end
      S_EX_ST:  begin w_alu = 4'd9;  w_en_f = 1'b1; w_next = S_MEM_ST; end
      S_EX_JAL: begin w_alu = 4'd10; w_en_f = 1'b1; w_next = S_WB_JAL; end
      S_EX_BR:  begin w_alu = 4'd11; w_en_pc = 1'b1; w_next = S_IFETCH; end
      S_EX_BZ:  begin w_alu = zero ? 4'd11 : 4'd10; w_en_pc = 1'b1; w_next = S_IFETCH; end
      S_EX_BN:  begin w_alu = neg ? 4'd11 : 4'd10;  w_en_pc = 1'b1; w_next = S_IFETCH; end
      S_EX_JR:  begin w_alu = 4'd13; w_en_pc = 1'b1; w_next = S_IFETCH; end
      S_EX_QUIT: begin w_alu = 4'd10; w_en_pc = 1'b1; w_next = S_HALT; end
      S_MEM_LD: begin
        w_mem_req = 1'b1;
        w_s_addr  = 1'b1;
        if (mem_ready) begin
          w_en_mdr = 1'b1;
          w_next   = S_WB_LD;
        end else if (w_timeout) begin
          w_next = S_FAULT;
        end
      end
      S_MEM_ST: begin
        w_mem_req = 1'b1;
        w_s_addr  = 1'b1;
        w_we_mem  = 1'b1;
        if (mem_ready) begin
          w_alu   = 4'd10;
          w_en_pc = 1'b1;
          w_next  = S_IFETCH;
        end else if (w_timeout) begin
          w_next = S_FAULT;
        end
      end
      S_WB_ALU: begin w_we_rf = 1'b1; w_alu = 4'd10; w_en_pc = 1'b1; w_next = S_IFETCH; end
      S_WB_LD: begin
        w_we_rf = 1'b1;
        w_din   = 1'b1;
        w_alu   = 4'd10;
        w_en_pc = 1'b1;
        w_next  = S_IFETCH;
      end
      S_WB_JAL: begin
        w_we_rf = 1'b1;
        w_rw    = 1'b1;
        w_alu   = 4'd12;
        w_en_pc = 1'b1;
        w_next  = S_IFETCH;
      end
      S_FAULT: w_next = S_FAULT;
      default: w_next = S_FAULT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_HALT;
      r_wait    <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      // Any transition clears the counter, which covers entry into a memory state.
      if (w_next != r_state)
        r_wait <= '0;
      else if (w_mem_req && !mem_ready && (MEM_TIMEOUT != 0))
        r_wait <= r_wait + 1'b1;
      if (w_en_pc)
        r_retired <= r_retired + 1'b1;
    end
  end

  assign mem_req       = w_mem_req;
  assign s_addr        = w_s_addr;
  assign we_mem        = w_we_mem;
  assign en_inst       = w_en_inst;
  assign en_a          = w_en_a;
  assign en_b          = w_en_b;
  assign en_f          = w_en_f;
  assign en_mdr        = w_en_mdr;
  assign en_pc         = w_en_pc;
  assign alu_op        = ALU_OP_W'(w_alu);
  assign s_regfile_din = w_din;
  assign s_regfile_rw  = w_rw;
  assign we_regfile    = w_we_rf;
  assign halted        = (r_state == S_HALT);
  assign fault         = (r_state == S_FAULT);
  assign retired_count = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_albacore_controller_ws.sv
`default_nettype none
// ============================================================================
// Module  : tb_albacore_controller_ws
// Brief   : Scoreboard bench for albacore_controller_ws using directed vectors.
// Rev     : 1.0
// ============================================================================
module tb_albacore_controller_ws;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] opcode;
  logic       zero, neg, mem_ready, run;
  logic       mem_req, s_addr, we_mem, en_inst, en_a, en_b, en_f, en_mdr, en_pc;
  logic [3:0] alu_op;
  logic       s_regfile_din, s_regfile_rw, we_regfile, halted, fault;
  logic [3:0] retired_count;

  albacore_controller_ws #(
    .OPCODE_W(5), .ALU_OP_W(4), .MEM_TIMEOUT(4), .RETIRE_W(4)
  ) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .neg(neg),
    .mem_ready(mem_ready), .run(run), .mem_req(mem_req), .s_addr(s_addr),
    .we_mem(we_mem), .en_inst(en_inst), .en_a(en_a), .en_b(en_b), .en_f(en_f),
    .en_mdr(en_mdr), .en_pc(en_pc), .alu_op(alu_op), .s_regfile_din(s_regfile_din),
    .s_regfile_rw(s_regfile_rw), .we_regfile(we_regfile), .halted(halted),
    .fault(fault), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  // Observation word: {mem_req,s_addr,we_mem,en_inst,en_a,en_b,en_f,en_mdr,en_pc,alu_op,din,rw,we_rf,halted,fault,retired}
  localparam logic [21:0] REQ = 22'd1 << 21;
  localparam logic [21:0] SA  = 22'd1 << 20;
  localparam logic [21:0] WEM = 22'd1 << 19;
  localparam logic [21:0] INS = 22'd1 << 18;
  localparam logic [21:0] EA  = 22'd1 << 17;
  localparam logic [21:0] EB  = 22'd1 << 16;
  localparam logic [21:0] EF  = 22'd1 << 15;
  localparam logic [21:0] MDR = 22'd1 << 14;
  localparam logic [21:0] PC  = 22'd1 << 13;
  localparam logic [21:0] DIN = 22'd1 << 8;
  localparam logic [21:0] RW  = 22'd1 << 7;
  localparam logic [21:0] WRF = 22'd1 << 6;
  localparam logic [21:0] H   = 22'd1 << 5;
  localparam logic [21:0] FLT = 22'd1 << 4;

  function automatic logic [21:0] alu(input int v);
    return 22'(v) << 9;
  endfunction

  typedef struct {
    string       nm;
    logic [21:0] e;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [3:0]  ret   = 4'd0;
  logic [21:0] obs;

  assign obs = {mem_req, s_addr, we_mem, en_inst, en_a, en_b, en_f, en_mdr, en_pc,
                alu_op, s_regfile_din, s_regfile_rw, we_regfile, halted, fault,
                retired_count};

  // Monitor: every mid-cycle sample with a pending expectation is checked.
  always @(negedge clk) begin : mon
    exp_t x;
    if (sb.size() != 0) begin
      x = sb.pop_front();
      tests++;
      if (obs !== x.e) begin
        fails++;
        $display("FAIL %s: got %h expected %h", x.nm, obs, x.e);
      end
    end
  end

  task automatic cyc(input logic [4:0] op, input logic rdy, input logic z, input logic n,
                     input logic rn, input logic rs, input logic [21:0] e, input string nm);
    rst = rs; opcode = op; mem_ready = rdy; zero = z; neg = n; run = rn;
    if (rs) ret = 4'd0;
    sb.push_back('{nm, e | 22'(ret)});
    if (!rs && e[13]) ret = ret + 4'd1;
    @(posedge clk); #1;
  endtask

  task automatic c(input logic [4:0] op, input logic rdy, input logic [21:0] e, input string nm);
    cyc(op, rdy, 1'b0, 1'b0, 1'b0, 1'b0, e, nm);
  endtask

  task automatic fetch(input logic [4:0] op, input string nm);
    c(op, 1'b1, REQ | INS, {nm, "_ifetch"});
    c(op, 1'b1, EA | EB,   {nm, "_decode"});
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; opcode = '0; mem_ready = 1'b0; zero = 1'b0; neg = 1'b0;
    @(posedge clk); #1;
    cyc(0, 0, 0, 0, 0, 1, H, "reset_state");
    cyc(0, 1, 0, 0, 1, 0, H, "halt_run");
    // ADD
    fetch(0, "add");
    c(0, 1, EF | alu(0), "add_ex");
    c(0, 1, WRF | alu(10) | PC, "add_wb");
    // ALU op 5 with one fetch wait
    c(5, 0, REQ, "op5_fetch_wait");
    fetch(5, "op5");
    c(5, 1, EF | alu(5), "op5_ex");
    c(5, 1, WRF | alu(10) | PC, "op5_wb");
    // LD with three not-ready cycles
    fetch(8, "ld");
    c(8, 1, EF | alu(8), "ld_ex");
    repeat (3) c(8, 0, REQ | SA, "ld_mem_wait");
    c(8, 1, REQ | SA | MDR, "ld_mem_ready");
    c(8, 1, WRF | DIN | alu(10) | PC, "ld_wb");
    // ST with two not-ready cycles
    fetch(9, "st");
    c(9, 1, EF | alu(9), "st_ex");
    repeat (2) c(9, 0, REQ | SA | WEM, "st_mem_wait");
    c(9, 1, REQ | SA | WEM | alu(10) | PC, "st_mem_ready");
    // Branches
    fetch(10, "br");
    c(10, 1, alu(11) | PC, "br_ex");
    fetch(11, "bz1");
    cyc(11, 1, 1, 0, 0, 0, alu(11) | PC, "bz_taken");
    fetch(11, "bz0");
    cyc(11, 1, 0, 1, 0, 0, alu(10) | PC, "bz_not_taken");
    fetch(12, "bn1");
    cyc(12, 1, 0, 1, 0, 0, alu(11) | PC, "bn_taken");
    fetch(12, "bn0");
    cyc(12, 1, 1, 0, 0, 0, alu(10) | PC, "bn_not_taken");
    fetch(13, "jal");
    c(13, 1, EF | alu(10), "jal_ex");
    c(13, 1, WRF | RW | alu(12) | PC, "jal_wb");
    fetch(14, "jr");
    c(14, 1, alu(13) | PC, "jr_ex");
    // QUIT then resume
    fetch(15, "quit");
    c(15, 1, alu(10) | PC, "quit_ex");
    c(0, 1, H, "halt_idle_no_req");
    cyc(0, 1, 0, 0, 1, 0, H, "halt_resume");
    // Retired counter wraps past 15
    for (int i = 0; i < 4; i++) begin
      fetch(3, "wrap");
      c(3, 1, EF | alu(3), "wrap_ex");
      c(3, 1, WRF | alu(10) | PC, "wrap_wb");
    end
    // Ready on the last allowed wait cycle still proceeds
    repeat (3) c(0, 0, REQ, "late_ready_wait");
    fetch(0, "late_ready");
    c(0, 1, EF | alu(0), "late_ready_ex");
    c(0, 1, WRF | alu(10) | PC, "late_ready_wb");
    // Fetch timeout
    repeat (4) c(0, 0, REQ, "timeout_wait");
    cyc(0, 1, 0, 0, 1, 0, FLT, "fault_run_ignored");
    cyc(0, 1, 0, 0, 1, 0, FLT, "fault_sticky");
    cyc(0, 1, 0, 0, 1, 1, H, "fault_rst");
    cyc(0, 1, 0, 0, 1, 0, H, "rst_release");
    // Illegal opcode
    fetch(16, "illegal");
    c(16, 1, FLT, "illegal_fault");
    cyc(0, 0, 0, 0, 0, 1, H, "illegal_rst");
    cyc(0, 0, 0, 0, 1, 0, H, "illegal_release");
    // Asynchronous reset in the middle of a store
    fetch(9, "st_rst");
    c(9, 1, EF | alu(9), "st_rst_ex");
    c(9, 0, REQ | SA | WEM, "st_rst_mem");
    cyc(9, 0, 0, 0, 0, 1, H, "rst_mid_st");
    cyc(0, 1, 0, 0, 0, 0, H, "post_rst_halt");
    @(posedge clk); #1;
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
